fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the front end. It owns the program counter and drives a single-outstanding request/response handshake to instruction memory. Fetched instructions are held in a one-entry output buffer with a valid/ready handshake toward decode, and branch/jump redirects from execute flush in-flight work. It replaces the free-running PC increment of the current fetch stage with stall- and redirect-aware sequencing.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_buf.sv | 35 +++
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: bus widths, reset PC, PC step and FSM state encodings.
package fetch_ctrl_pkg;

  localparam int ADDR_BUS = 64;
  localparam int INST_BUS = 32;

  localparam logic [ADDR_BUS-1:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [ADDR_BUS-1:0] FETCH_PC_INC   = 64'd4;

  typedef enum logic [1:0] {
    FETCH_ST_REQ  = 2'd0,
    FETCH_ST_WAIT = 2'd1,
    FETCH_ST_ERR  = 2'd2
  } fetch_st_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register for {pc, inst} toward decode, with flush.
module fetch_buf #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  input  logic              rd_en,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  // Data is held after a drain so inst/inst_pc stay stable; only valid clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      pc    <= wr_pc;
      inst  <= wr_inst;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, single-outstanding imem handshake, redirect flush.
// Optional misaligned-redirect halt enabled by defining ZEROCPU_FETCH_ALIGN_CHK_EN.
//
// state | meaning
// REQ   | request pending, issues when the buffer is free or draining
// WAIT  | one request outstanding, waiting for imem_rvalid
// ERR   | halted on a misaligned redirect target (only with the alignment check)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst,
  output logic              fetch_err
);

  fetch_st_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              kill_q, kill_d;
  logic              buf_valid, buf_wr, buf_free, outstanding, misaligned;

  assign buf_free    = !buf_valid || inst_ready;
  assign imem_req    = !rst && (state_q == FETCH_ST_REQ) && buf_free && !redirect_valid;
  assign imem_addr   = pc_q;
  assign inst_valid  = buf_valid && !redirect_valid;
  assign outstanding = (state_q == FETCH_ST_WAIT) || kill_q;

`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
  logic err_q, err_d;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign fetch_err  = err_q;
`else
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    buf_wr   = 1'b0;
`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
    err_d    = err_q;
`endif
    if (redirect_valid) begin
      // A response landing in the redirect cycle retires the outstanding request itself.
      pc_d   = redirect_pc;
      kill_d = outstanding && !imem_rvalid;
`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
      err_d  = misaligned;
`endif
      if (misaligned)  state_d = FETCH_ST_ERR;
      else if (kill_d) state_d = FETCH_ST_WAIT;
      else             state_d = FETCH_ST_REQ;
    end else begin
      unique case (state_q)
        FETCH_ST_REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc_d = pc_q;
            state_d  = FETCH_ST_WAIT;
          end
        end
        FETCH_ST_WAIT: begin
          if (imem_rvalid) begin
            if (!kill_q) begin
              buf_wr = 1'b1;
              pc_d   = req_pc_q + ADDR_W'(FETCH_PC_INC);
            end
            kill_d  = 1'b0;
            state_d = FETCH_ST_REQ;
          end
        end
`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
        FETCH_ST_ERR: begin
          if (imem_rvalid) kill_d = 1'b0;
        end
`endif
        default: state_d = FETCH_ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (buf_wr),
    .wr_pc   (req_pc_q),
    .wr_inst (imem_rdata),
    .rd_en   (inst_valid && inst_ready),
    .valid   (buf_valid),
    .pc      (inst_pc),
    .inst    (inst)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-driven imem/decode/redirect per cycle, expected values written inline.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic        fetch_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    chkb("rst_req",   imem_req,   1'b0);
    chka("rst_addr",  imem_addr,  64'h0000_0000_8000_0000);
    chkb("rst_ival",  inst_valid, 1'b0);
    chka("rst_ipc",   inst_pc,    64'h0);
    chki("rst_inst",  inst,       32'h0);
    chkb("rst_err",   fetch_err,  1'b0);

    // Streaming at k=1, ready high: one instruction every 2 cycles
    rst = 1'b0; imem_gnt = 1'b1; #1;
    chkb("first_req",  imem_req,  1'b1);
    chka("first_addr", imem_addr, 64'h8000_0000);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
    chkb("wait0_req",  imem_req,   1'b0);
    chkb("wait0_ival", inst_valid, 1'b0);
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("d0_ival", inst_valid, 1'b1);
    chka("d0_ipc",  inst_pc,    64'h8000_0000);
    chki("d0_inst", inst,       32'h0000_0013);
    chkb("d0_req",  imem_req,   1'b1);
    chka("d0_addr", imem_addr,  64'h8000_0004);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093; #1;
    chkb("wait1_ival", inst_valid, 1'b0);
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("d1_ival", inst_valid, 1'b1);
    chka("d1_ipc",  inst_pc,    64'h8000_0004);
    chki("d1_inst", inst,       32'h0010_0093);
    chka("d1_addr", imem_addr,  64'h8000_0008);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113; #1;

    // Decode stall for 5 cycles with an instruction held
    nxt(); imem_rvalid = 1'b0; inst_ready = 1'b0; #1;
    chkb("d2_ival", inst_valid, 1'b1);
    chka("d2_ipc",  inst_pc,    64'h8000_0008);
    chki("d2_inst", inst,       32'h0020_0113);
    chkb("stall_req0", imem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chkb("stall_req",  imem_req,   1'b0);
      chkb("stall_ival", inst_valid, 1'b1);
      chka("stall_ipc",  inst_pc,    64'h8000_0008);
      chki("stall_inst", inst,       32'h0020_0113);
    end
    nxt(); inst_ready = 1'b1; imem_gnt = 1'b1; #1;
    chkb("unstall_req",  imem_req,  1'b1);
    chka("unstall_addr", imem_addr, 64'h8000_000C);

    // Redirect during WAIT, response arrives 3 cycles after grant and is dropped
    nxt(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; #1;
    chkb("rdw_req",  imem_req,   1'b0);
    chkb("rdw_ival", inst_valid, 1'b0);
    nxt(); redirect_valid = 1'b0; #1;
    chkb("kill_req", imem_req, 1'b0);
    nxt(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chkb("stale_ival", inst_valid, 1'b0);
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("drop_ival", inst_valid, 1'b0);
    chkb("rd1_req",   imem_req,   1'b1);
    chka("rd1_addr",  imem_addr,  64'h8000_0100);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; #1;

    // Redirect in the same cycle as a decode transfer
    nxt(); imem_rvalid = 1'b0; #1;
    chkb("pre_void_ival", inst_valid, 1'b1);
    chka("pre_void_ipc",  inst_pc,    64'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; #1;
    chkb("void_ival", inst_valid, 1'b0);
    chkb("void_req",  imem_req,   1'b0);
    nxt(); redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("flushed_ival", inst_valid, 1'b0);
    chkb("rd2_req",      imem_req,   1'b1);
    chka("rd2_addr",     imem_addr,  64'h8000_0200);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; #1;
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chka("rd2_ipc",  inst_pc,   64'h8000_0200);
    chki("rd2_inst", inst,      32'h2222_2222);
    chka("rd2_next", imem_addr, 64'h8000_0204);

    // Back-to-back redirects while WAIT: one response discarded, 0x200 wins
    nxt(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100; #1;
    nxt(); redirect_pc = 64'h200; #1;
    chkb("dbl_req", imem_req, 1'b0);
    nxt(); redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; #1;
    chkb("dbl_stale_ival", inst_valid, 1'b0);
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("dbl_ival", inst_valid, 1'b0);
    chkb("dbl_req2", imem_req,   1'b1);
    chka("dbl_addr", imem_addr,  64'h200);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; #1;
    nxt(); imem_rvalid = 1'b0; #1;
    chkb("dbl_dval", inst_valid, 1'b1);
    chka("dbl_ipc",  inst_pc,    64'h200);
    chki("dbl_inst", inst,       32'h4444_4444);
    chka("dbl_next", imem_addr,  64'h204);

    // PC wrap at the top of the address space
    nxt(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    nxt(); redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
    chka("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; #1;
    nxt(); imem_rvalid = 1'b0; #1;
    chka("wrap_ipc",  inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
    chka("wrap_next", imem_addr, 64'h0);

    // Misaligned redirect target
    nxt(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; #1;
    nxt(); redirect_valid = 1'b0; #1;
`ifdef ZEROCPU_FETCH_ALIGN_CHK_EN
    chkb("mis_err", fetch_err, 1'b1);
    chkb("mis_req", imem_req,  1'b0);
    nxt(); #1;
    chkb("mis_req2", imem_req,  1'b0);
    chkb("mis_err2", fetch_err, 1'b1);
    nxt(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; #1;
    chkb("mis_err3", fetch_err, 1'b1);
    nxt(); redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
    chkb("clr_err",  fetch_err, 1'b0);
    chkb("clr_req",  imem_req,  1'b1);
    chka("clr_addr", imem_addr, 64'h8000_0200);
`else
    chkb("mis_err",  fetch_err, 1'b0);
    chkb("mis_req",  imem_req,  1'b1);
    chka("mis_addr", imem_addr, 64'h8000_0102);
    imem_gnt = 1'b1;
    nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666; #1;
    nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
    chka("mis_ipc",  inst_pc,   64'h8000_0102);
    chki("mis_inst", inst,      32'h6666_6666);
    chka("mis_next", imem_addr, 64'h8000_0106);
    chkb("mis_err2", fetch_err, 1'b0);
`endif

    // Reset with a request outstanding
    nxt(); imem_gnt = 1'b0; rst = 1'b1; #1;
    chkb("mrst_req0", imem_req, 1'b0);
    nxt(); #1;
    chka("mrst_addr", imem_addr,  64'h8000_0000);
    chkb("mrst_ival", inst_valid, 1'b0);
    chka("mrst_ipc",  inst_pc,    64'h0);
    chkb("mrst_err",  fetch_err,  1'b0);
    nxt(); rst = 1'b0; #1;
    chkb("mrst_req1",  imem_req,  1'b1);
    chka("mrst_addr1", imem_addr, 64'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
